frame_accumulator: RTL and testbench

- Downstream stage of the 10-bit operand adder.
- Consumes its unsigned sum stream over a valid/ready handshake.
- Accumulates FRAME_LEN consecutive sums into one widened frame total and presents it over a valid/ready output handshake.
- Feeds the FFT bin-energy/statistics path. Output width grows so no frame total ever wraps.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/frame_accumulator.sv | 69 ++++++
 tb/tb_frame_accumulator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Widths shared by the FFT front-end stages (operand adder, frame accumulator).
package fft_pkg;

  localparam int unsigned DATA_W_DEF = 10;
  localparam int unsigned IDX_W      = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    if (n > 1) begin
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
    end
    return r;
  endfunction

  // Frame total width: enough headroom that frame_len full-scale samples never wrap.
  function automatic int unsigned acc_w(input int unsigned data_w, input int unsigned frame_len);
    return data_w + clog2(frame_len);
  endfunction

endpackage

// File: rtl/frame_accumulator.sv
// Sums FRAME_LEN consecutive adder samples into one widened frame total,
// with valid/ready on both sides; the next frame accumulates while a total is pending.
module frame_accumulator
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned FRAME_LEN = 8,
  localparam int unsigned ACC_W    = acc_w(DATA_W, FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [IDX_W-1:0]  frame_idx
);

  localparam int unsigned      CNT_W    = (clog2(FRAME_LEN) > 0) ? clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_c;
  logic [CNT_W-1:0] cnt;
  logic             rdy_en;
  logic             last_c;
  logic             in_hs_c;
  logic             out_hs_c;

  assign sum_c    = acc + ACC_W'(in_data);
  assign last_c   = (cnt == CNT_LAST);
  // Only the completing sample stalls, and only while the previous total is unaccepted.
  assign in_ready = rdy_en && !(out_valid && !out_ready && last_c);
  assign in_hs_c  = in_valid && in_ready;
  assign out_hs_c = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      rdy_en    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      frame_idx <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (out_hs_c) begin
        out_valid <= 1'b0;
        frame_idx <= frame_idx + IDX_W'(1);
      end
      // A completing sample can only be taken when the output slot is free or draining,
      // so the load below never overwrites an undelivered total.
      if (in_hs_c) begin
        if (last_c) begin
          out_data  <= sum_c;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench: FRAME_LEN=4 instance driven from a vector table plus reset corners,
// and a FRAME_LEN=1 instance streamed continuously through the frame_idx wrap.
module tb_frame_accumulator;

  logic clk;
  logic rst_n;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [9:0]  in_data4;
  logic [11:0] out_data4;
  logic [7:0]  frame_idx4;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  logic [9:0]  in_data1;
  logic [9:0]  out_data1;
  logic [7:0]  frame_idx1;

  int checks   = 0;
  int failures = 0;

  frame_accumulator #(.DATA_W(10), .FRAME_LEN(4)) u_acc4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .frame_idx(frame_idx4)
  );

  frame_accumulator #(.DATA_W(10), .FRAME_LEN(1)) u_acc1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .frame_idx(frame_idx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [9:0]  d;
    logic        ordy;
    logic        ov;
    logic [11:0] od;
    logic [7:0]  idx;
    logic        ir;
  } vec_t;

  localparam int NVEC = 35;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic iv, input int d, input logic ordy,
                              input logic ov, input int od, input int idx, input logic ir);
    vec_t v;
    v.iv = iv; v.d = 10'(d); v.ordy = ordy;
    v.ov = ov; v.od = 12'(od); v.idx = 8'(idx); v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic iv, input int d, input logic ordy);
    in_valid4  = iv;
    in_data4   = 10'(d);
    out_ready4 = ordy;
  endtask

  initial begin
    // Each row: inputs for this cycle | state seen before the edge + in_ready for these inputs.
    // frame 1,2,3,4 -> 10
    tbl[0]  = mk(1, 1,    1, 0, 0,    0, 1);
    tbl[1]  = mk(1, 2,    1, 0, 0,    0, 1);
    tbl[2]  = mk(1, 3,    1, 0, 0,    0, 1);
    tbl[3]  = mk(1, 4,    1, 0, 0,    0, 1);
    tbl[4]  = mk(0, 0,    1, 1, 10,   0, 1);
    // full-scale frame -> 4092, then zero frame -> 0
    tbl[5]  = mk(1, 1023, 1, 0, 10,   1, 1);
    tbl[6]  = mk(1, 1023, 1, 0, 10,   1, 1);
    tbl[7]  = mk(1, 1023, 1, 0, 10,   1, 1);
    tbl[8]  = mk(1, 1023, 1, 0, 10,   1, 1);
    tbl[9]  = mk(1, 0,    1, 1, 4092, 1, 1);
    tbl[10] = mk(1, 0,    1, 0, 4092, 2, 1);
    tbl[11] = mk(1, 0,    1, 0, 4092, 2, 1);
    tbl[12] = mk(1, 0,    1, 0, 4092, 2, 1);
    tbl[13] = mk(0, 0,    1, 1, 0,    2, 1);
    // bubbles carrying junk data: 5,6,7,8 -> 26
    tbl[14] = mk(1, 5,    1, 0, 0,    3, 1);
    tbl[15] = mk(0, 999,  1, 0, 0,    3, 1);
    tbl[16] = mk(1, 6,    1, 0, 0,    3, 1);
    tbl[17] = mk(0, 999,  1, 0, 0,    3, 1);
    tbl[18] = mk(1, 7,    1, 0, 0,    3, 1);
    tbl[19] = mk(0, 999,  1, 0, 0,    3, 1);
    tbl[20] = mk(1, 8,    1, 0, 0,    3, 1);
    tbl[21] = mk(0, 0,    1, 1, 26,   3, 1);
    // backpressure: A=1,1,1,1 held, B=2,2,2,2 stalls on its last sample
    tbl[22] = mk(1, 1,    0, 0, 26,   4, 1);
    tbl[23] = mk(1, 1,    0, 0, 26,   4, 1);
    tbl[24] = mk(1, 1,    0, 0, 26,   4, 1);
    tbl[25] = mk(1, 1,    0, 0, 26,   4, 1);
    tbl[26] = mk(1, 2,    0, 1, 4,    4, 1);
    tbl[27] = mk(1, 2,    0, 1, 4,    4, 1);
    tbl[28] = mk(1, 2,    0, 1, 4,    4, 1);
    tbl[29] = mk(1, 2,    0, 1, 4,    4, 0);
    tbl[30] = mk(1, 2,    0, 1, 4,    4, 0);
    tbl[31] = mk(1, 2,    1, 1, 4,    4, 1);
    tbl[32] = mk(0, 0,    0, 1, 8,    5, 1);
    tbl[33] = mk(0, 0,    1, 1, 8,    5, 1);
    tbl[34] = mk(0, 0,    1, 0, 8,    6, 1);

    rst_n = 1'b0;
    drive4(0, 0, 0);
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready4), 0);
    chk("rst_out_valid", 32'(out_valid4), 0);
    chk("rst_out_data", 32'(out_data4), 0);
    chk("rst_frame_idx", 32'(frame_idx4), 0);
    chk("rst1_out_valid", 32'(out_valid1), 0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready4), 1);

    for (int i = 0; i < NVEC; i++) begin
      drive4(tbl[i].iv, int'(tbl[i].d), tbl[i].ordy);
      #1;
      chk($sformatf("r%0d_out_valid", i), 32'(out_valid4), 32'(tbl[i].ov));
      chk($sformatf("r%0d_out_data", i), 32'(out_data4), 32'(tbl[i].od));
      chk($sformatf("r%0d_frame_idx", i), 32'(frame_idx4), 32'(tbl[i].idx));
      chk($sformatf("r%0d_in_ready", i), 32'(in_ready4), 32'(tbl[i].ir));
      @(posedge clk);
      #1;
    end

    // Partial frame 3,3 is discarded by a one-edge reset.
    drive4(1, 3, 1); cyc();
    drive4(1, 3, 1); cyc();
    drive4(0, 0, 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready4), 0);
    chk("midrst_out_valid", 32'(out_valid4), 0);
    chk("midrst_frame_idx", 32'(frame_idx4), 0);
    chk("midrst_out_data", 32'(out_data4), 0);
    cyc();
    chk("midrst_ready_back", 32'(in_ready4), 1);
    for (int k = 0; k < 4; k++) begin
      drive4(1, 1, 0);
      cyc();
    end
    drive4(0, 0, 0);
    #1;
    chk("after_rst_out_valid", 32'(out_valid4), 1);
    chk("after_rst_out_data", 32'(out_data4), 4);
    chk("after_rst_frame_idx", 32'(frame_idx4), 0);

    // A pending total is dropped by reset, never delivered.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("pend_rst_out_valid", 32'(out_valid4), 0);
    chk("pend_rst_out_data", 32'(out_data4), 0);
    drive4(0, 0, 1);
    cyc();
    cyc();
    chk("pend_rst_stays_idle", 32'(out_valid4), 0);
    chk("pend_rst_idx", 32'(frame_idx4), 0);

    // FRAME_LEN=1: one total per cycle, frame_idx wraps on the 256th handshake.
    out_ready1 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid1 = 1'b1;
      in_data1  = 10'(i % 1024);
      #1;
      chk($sformatf("fl1_in_ready_%0d", i), 32'(in_ready1), 1);
      cyc();
      chk($sformatf("fl1_out_valid_%0d", i), 32'(out_valid1), 1);
      chk($sformatf("fl1_out_data_%0d", i), 32'(out_data1), 32'(i % 1024));
      chk($sformatf("fl1_frame_idx_%0d", i), 32'(frame_idx1), 32'(i % 256));
    end
    in_valid1 = 1'b0;
    cyc();
    chk("fl1_drain_valid", 32'(out_valid1), 0);
    chk("fl1_final_idx", 32'(frame_idx1), 32'(300 % 256));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
